// File: rtl/mult_add_pipe_if.sv
// Sample/result bus for mult_add_pipe.
// The ovf signal exists only when MULT_ADD_OVF_EN is defined.
interface mult_add_pipe_if #(
  parameter int WIDTH = 18
);
  logic                 in_valid;
  logic [1:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   c;
  logic [2*WIDTH-1:0]   p;
  logic                 out_valid;
`ifdef MULT_ADD_OVF_EN
  logic                 ovf;
`endif

  modport master (
    output in_valid, op, a, b, c,
`ifdef MULT_ADD_OVF_EN
    input  ovf,
`endif
    input  p, out_valid
  );

  modport slave (
    input  in_valid, op, a, b, c,
`ifdef MULT_ADD_OVF_EN
    output ovf,
`endif
    output p, out_valid
  );
endinterface

// File: rtl/mult_add_pipe.sv
// Pipelined multiply-add: IN_STAGES ingress stages carrying a/b/op/valid
// (and c when C_ALIGN=1), then one output stage computing
//   op 00: A*B+C   01: A*B-C   10: A*B+P   11: A*B
// Bubbles leave p untouched so accumulation chains survive gaps.
// Optional MULT_ADD_OVF_EN adds a sticky carry/borrow flag (ovf),
// cleared by sclr or by a valid load (op=11).
module mult_add_pipe #(
  parameter int WIDTH     = 18,
  parameter int IN_STAGES = 2,
  parameter int C_ALIGN   = 0
) (
  input  logic            clk,
  input  logic            sclr,
  input  logic            ce,
  mult_add_pipe_if.slave  bus
);

  localparam int PW = 2 * WIDTH;
`ifdef MULT_ADD_OVF_EN
  // One extra bit holds the carry (add/acc) or borrow (sub).
  localparam int RW = PW + 1;
`else
  localparam int RW = PW;
`endif

  logic [WIDTH-1:0] a_q   [IN_STAGES];
  logic [WIDTH-1:0] a_d   [IN_STAGES];
  logic [WIDTH-1:0] b_q   [IN_STAGES];
  logic [WIDTH-1:0] b_d   [IN_STAGES];
  logic [1:0]       op_q  [IN_STAGES];
  logic [1:0]       op_d  [IN_STAGES];
  logic             vld_q [IN_STAGES];
  logic             vld_d [IN_STAGES];

  logic [PW-1:0]    p_q, p_d;
  logic             out_valid_q, out_valid_d;
`ifdef MULT_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [PW-1:0]    c_sel;
  logic [PW-1:0]    prod;
  logic [RW-1:0]    res;
  logic [1:0]       op_last;
  logic             vld_last;

  // Ingress shift register; everything holds while ce is low.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    vld_d = vld_q;
    if (ce) begin
      a_d[0]   = bus.a;
      b_d[0]   = bus.b;
      op_d[0]  = bus.op;
      vld_d[0] = bus.in_valid;
      for (int i = 1; i < IN_STAGES; i++) begin
        a_d[i]   = a_q[i-1];
        b_d[i]   = b_q[i-1];
        op_d[i]  = op_q[i-1];
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  // Ingress registers; sclr wipes every in-flight sample.
  always_ff @(posedge clk) begin
    if (sclr) begin
      for (int i = 0; i < IN_STAGES; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        op_q[i]  <= '0;
        vld_q[i] <= 1'b0;
      end
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      vld_q <= vld_d;
    end
  end

  // Addend source: travelling with the sample, or straight off the port.
  generate
    if (C_ALIGN != 0) begin : g_c_align
      logic [PW-1:0] c_q [IN_STAGES];
      logic [PW-1:0] c_d [IN_STAGES];

      // Addend shift register alongside a/b.
      always_comb begin
        c_d = c_q;
        if (ce) begin
          c_d[0] = bus.c;
          for (int i = 1; i < IN_STAGES; i++) begin
            c_d[i] = c_q[i-1];
          end
        end
      end

      // Addend registers, cleared with the rest of the pipe.
      always_ff @(posedge clk) begin
        if (sclr) begin
          for (int i = 0; i < IN_STAGES; i++) begin
            c_q[i] <= '0;
          end
        end else begin
          c_q <= c_d;
        end
      end

      assign c_sel = c_q[IN_STAGES-1];
    end else begin : g_c_port
      assign c_sel = bus.c;
    end
  endgenerate

  assign op_last  = op_q[IN_STAGES-1];
  assign vld_last = vld_q[IN_STAGES-1];
  assign prod     = {{WIDTH{1'b0}}, a_q[IN_STAGES-1]} *
                    {{WIDTH{1'b0}}, b_q[IN_STAGES-1]};

  // Result of the delayed op; wraps modulo 2^PW, top bit is carry/borrow
  // when the overflow flag is built.
  always_comb begin
    res = RW'(prod);
    case (op_last)
      2'b00:   res = RW'(prod) + RW'(c_sel);
      2'b01:   res = RW'(prod) - RW'(c_sel);
      2'b10:   res = RW'(prod) + RW'(p_q);
      default: res = RW'(prod);
    endcase
  end

  // Output stage: update on a valid sample, hold p across bubbles.
  always_comb begin
    p_d         = p_q;
    out_valid_d = out_valid_q;
`ifdef MULT_ADD_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (ce) begin
      out_valid_d = vld_last;
      if (vld_last) begin
        p_d = res[PW-1:0];
`ifdef MULT_ADD_OVF_EN
        if (op_last == 2'b11) begin
          ovf_d = 1'b0;
        end else if (res[PW]) begin
          ovf_d = 1'b1;
        end
`endif
      end
    end
  end

  // Output registers; sclr overrides ce.
  always_ff @(posedge clk) begin
    if (sclr) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
`ifdef MULT_ADD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
`ifdef MULT_ADD_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.p         = p_q;
  assign bus.out_valid = out_valid_q;
`ifdef MULT_ADD_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_mult_add_pipe.sv
// Bench for mult_add_pipe: two instances (default 18/2/0 and 8/4/1)
// checked every cycle against a queue-based arithmetic model, plus
// directed scenarios with fixed expected values.
module tb_mult_add_pipe;

  logic clk = 1'b0;
  logic sclr;
  logic ce_in [2];
  logic v_in  [2];
  logic [1:0]  op_in [2];
  logic [63:0] a_in  [2];
  logic [63:0] b_in  [2];
  logic [63:0] c_in  [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_add_pipe_if #(.WIDTH(18)) ifc0 ();
  mult_add_pipe_if #(.WIDTH(8))  ifc1 ();

  assign ifc0.in_valid = v_in[0];
  assign ifc0.op       = op_in[0];
  assign ifc0.a        = a_in[0][17:0];
  assign ifc0.b        = b_in[0][17:0];
  assign ifc0.c        = c_in[0][35:0];
  assign ifc1.in_valid = v_in[1];
  assign ifc1.op       = op_in[1];
  assign ifc1.a        = a_in[1][7:0];
  assign ifc1.b        = b_in[1][7:0];
  assign ifc1.c        = c_in[1][15:0];

  mult_add_pipe #(.WIDTH(18), .IN_STAGES(2), .C_ALIGN(0)) dut0 (
    .clk(clk), .sclr(sclr), .ce(ce_in[0]), .bus(ifc0));
  mult_add_pipe #(.WIDTH(8), .IN_STAGES(4), .C_ALIGN(1)) dut1 (
    .clk(clk), .sclr(sclr), .ce(ce_in[1]), .bus(ifc1));

  // ---------------- reference model ----------------
  typedef struct {
    bit              v;
    bit [1:0]        op;
    longint unsigned a;
    longint unsigned b;
    longint unsigned c;
  } smp_t;

  smp_t            pipe [2][$];
  longint unsigned m_p   [2];
  bit              m_ov  [2];
  bit              m_ovf [2];
  int              stg [2] = '{2, 4};
  int              wd  [2] = '{18, 8};
  bit              cal [2] = '{1'b0, 1'b1};

  function automatic void model_edge(int d);
    longint unsigned am, pm, prod, cv, full;
    smp_t s;
    am = (64'd1 << wd[d]) - 1;
    pm = (64'd1 << (2 * wd[d])) - 1;
    if (sclr) begin
      pipe[d].delete();
      m_p[d]   = 0;
      m_ov[d]  = 0;
      m_ovf[d] = 0;
    end else if (ce_in[d]) begin
      s.v  = v_in[d];
      s.op = op_in[d];
      s.a  = a_in[d] & am;
      s.b  = b_in[d] & am;
      s.c  = c_in[d] & pm;
      pipe[d].push_back(s);
      m_ov[d] = 0;
      if (pipe[d].size() > stg[d]) begin
        s = pipe[d].pop_front();
        if (s.v) begin
          prod = s.a * s.b;
          cv   = cal[d] ? s.c : (c_in[d] & pm);
          case (s.op)
            2'd0: begin
              full = prod + cv;
              if (full > pm) m_ovf[d] = 1;
              m_p[d] = full & pm;
            end
            2'd1: begin
              if (prod < cv) m_ovf[d] = 1;
              m_p[d] = (prod - cv) & pm;
            end
            2'd2: begin
              full = prod + m_p[d];
              if (full > pm) m_ovf[d] = 1;
              m_p[d] = full & pm;
            end
            default: begin
              m_p[d]   = prod;
              m_ovf[d] = 0;
            end
          endcase
          m_ov[d] = 1;
        end
      end
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    chk("p0",  64'(ifc0.p),         m_p[0]);
    chk("ov0", 64'(ifc0.out_valid), 64'(m_ov[0]));
    chk("p1",  64'(ifc1.p),         m_p[1]);
    chk("ov1", 64'(ifc1.out_valid), 64'(m_ov[1]));
`ifdef MULT_ADD_OVF_EN
    chk("ovf0", 64'(ifc0.ovf), 64'(m_ovf[0]));
    chk("ovf1", 64'(ifc1.ovf), 64'(m_ovf[1]));
`endif
  endtask

  task automatic set_in(input int d, input bit v, input bit [1:0] op,
                        input longint unsigned a, input longint unsigned b,
                        input longint unsigned c);
    v_in[d]  = v;
    op_in[d] = op;
    a_in[d]  = a;
    b_in[d]  = b;
    c_in[d]  = c;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  logic [63:0] hold_p;

  initial begin
    sclr = 1'b1;
    ce_in[0] = 1'b1;
    ce_in[1] = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0, 0);
    @(negedge clk);

    // reset state
    step();
    step();
    chk("rst_p0",  64'(ifc0.p), 0);
    chk("rst_ov0", 64'(ifc0.out_valid), 0);
    chk("rst_p1",  64'(ifc1.p), 0);
    sclr = 1'b0;

    // default config: 3*5+7 after three edges
    set_in(0, 1, 2'b00, 3, 5, 7);
    step();
    set_in(0, 0, 2'b00, 0, 0, 7);
    step();
    chk("lat_early_ov", 64'(ifc0.out_valid), 0);
    step();
    chk("lat_p",  64'(ifc0.p), 22);
    chk("lat_ov", 64'(ifc0.out_valid), 1);
    step();
    chk("lat_ov_drop", 64'(ifc0.out_valid), 0);
    chk("lat_p_hold",  64'(ifc0.p), 22);

    // accumulate back to back: 4, 13, 17
    begin
      longint unsigned exp_acc [3] = '{4, 13, 17};
      for (int i = 0; i < 5; i++) begin
        case (i)
          0: set_in(0, 1, 2'b11, 2, 2, $urandom);
          1: set_in(0, 1, 2'b10, 3, 3, $urandom);
          2: set_in(0, 1, 2'b10, 1, 4, $urandom);
          default: set_in(0, 0, 2'b00, 0, 0, 0);
        endcase
        step();
        if (i >= 2) chk("acc_seq", 64'(ifc0.p), exp_acc[i-2]);
      end
    end

    // accumulate with bubbles
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: set_in(0, 1, 2'b11, 2, 2, 0);
        2: set_in(0, 1, 2'b10, 3, 3, 0);
        4: set_in(0, 1, 2'b10, 1, 4, 0);
        default: set_in(0, 0, 2'b10, $urandom, $urandom, 0);
      endcase
      step();
      if (i == 3) begin
        chk("bub_hold_p",  64'(ifc0.p), 4);
        chk("bub_hold_ov", 64'(ifc0.out_valid), 0);
      end
    end
    chk("bub_final", 64'(ifc0.p), 17);

    // WIDTH=8 subtract wrap and sticky overflow
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: set_in(1, 1, 2'b01, 1, 1, 2);
        1: set_in(1, 1, 2'b00, 3, 3, 1);
        2: set_in(1, 1, 2'b11, 2, 3, 9);
        default: set_in(1, 0, 2'b00, 0, 0, 0);
      endcase
      step();
      if (i == 4) begin
        chk("sub_wrap", 64'(ifc1.p), 64'hFFFF);
`ifdef MULT_ADD_OVF_EN
        chk("sub_ovf", 64'(ifc1.ovf), 1);
`endif
      end
      if (i == 5) begin
        chk("after_sub_add", 64'(ifc1.p), 10);
`ifdef MULT_ADD_OVF_EN
        chk("ovf_sticky", 64'(ifc1.ovf), 1);
`endif
      end
      if (i == 6) begin
        chk("load_p", 64'(ifc1.p), 6);
`ifdef MULT_ADD_OVF_EN
        chk("ovf_clr", 64'(ifc1.ovf), 0);
`endif
      end
    end

    // ce stall with IN_STAGES=4: result after 5 ce-enabled edges
    idle(5);
    set_in(1, 1, 2'b00, 7, 9, 5);
    step();
    set_in(1, 0, 2'b00, 0, 0, 0);
    step();
    hold_p = 64'(m_p[1]);
    ce_in[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_p",  64'(ifc1.p), hold_p);
      chk("stall_ov", 64'(ifc1.out_valid), 0);
    end
    ce_in[1] = 1'b1;
    step();
    step();
    chk("stall_ce4_ov", 64'(ifc1.out_valid), 0);
    step();
    chk("stall_ce5_p",  64'(ifc1.p), 68);
    chk("stall_ce5_ov", 64'(ifc1.out_valid), 1);
    ce_in[1] = 1'b0;
    step();
    step();
    chk("frz_ov", 64'(ifc1.out_valid), 1);
    chk("frz_p",  64'(ifc1.p), 68);
    ce_in[1] = 1'b1;
    step();
    chk("frz_release_ov", 64'(ifc1.out_valid), 0);

    // addend alignment: port-time c vs ingress-time c
    set_in(0, 1, 2'b00, 10, 10, 100);
    set_in(1, 1, 2'b00, 10, 10, 100);
    step();
    idle(5);
    chk("calign0", 64'(ifc0.p), 100);
    chk("calign1", 64'(ifc1.p), 200);

    // sclr with samples in flight and ce low
    set_in(0, 1, 2'b00, 11, 12, 13);
    set_in(1, 1, 2'b00, 11, 12, 13);
    step();
    step();
    ce_in[0] = 1'b0;
    ce_in[1] = 1'b0;
    sclr = 1'b1;
    step();
    chk("clr_p0",  64'(ifc0.p), 0);
    chk("clr_ov0", 64'(ifc0.out_valid), 0);
    chk("clr_p1",  64'(ifc1.p), 0);
    chk("clr_ov1", 64'(ifc1.out_valid), 0);
    sclr = 1'b0;
    ce_in[0] = 1'b1;
    ce_in[1] = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("no_stale0", 64'(ifc0.out_valid), 0);
      chk("no_stale1", 64'(ifc1.out_valid), 0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        set_in(d, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
               $urandom, $urandom, {$urandom, $urandom});
        ce_in[d] = $urandom_range(0, 7) != 0;
      end
      sclr = $urandom_range(0, 63) == 0;
      step();
    end
    sclr = 1'b0;
    ce_in[0] = 1'b1;
    ce_in[1] = 1'b1;
    idle(6);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
